// File: rtl/osp_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osp_cmd_pkg
// Purpose  : Shared types and constants for the OSP command queue slice.
//            - osp_cmd_t       : 16-bit OSP command word
//            - issue_state_e   : issue FSM states (IDLE, WAIT)
//            - c_mcu_cmd_rst   : reset value of the issued-command register
// Revision : 1.0 - initial release
// ============================================================================
package osp_cmd_pkg;

  typedef logic [15:0] osp_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } issue_state_e;

  localparam osp_cmd_t c_mcu_cmd_rst = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/osp_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : osp_cmd_queue_if
// Purpose  : Bus-side bundle of the OSP command queue.
//   master : drives wr_en, wr_data, flush, hold, ovf_clr;
//            observes mcu_cmd, mcu_cmd_write, full, empty, level, overflow
//   slave  : the queue itself (mirror directions)
// Revision : 1.0 - initial release
// ============================================================================
interface osp_cmd_queue_if
  import osp_cmd_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en;
  osp_cmd_t      wr_data;
  logic          flush;
  logic          hold;
  logic          ovf_clr;
  osp_cmd_t      mcu_cmd;
  logic          mcu_cmd_write;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (
    output wr_en, wr_data, flush, hold, ovf_clr,
    input  mcu_cmd, mcu_cmd_write, full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, hold, ovf_clr,
    output mcu_cmd, mcu_cmd_write, full, empty, level, overflow
  );

endinterface
`default_nettype wire

// File: rtl/osp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : osp_sync_fifo
// Purpose  : Generic synchronous FIFO with flush, for OSP buffers.
//   clk, reset_n     : clock, synchronous active-low reset
//   push_i, data_i   : write request / data (accepted when not full or
//                      when a pop happens in the same cycle)
//   pop_i            : read request (ignored when empty)
//   flush_i          : discard all entries; blocks push and pop that cycle
//   data_o           : head entry
//   level_o, full_o, empty_o : registered occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module osp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  // DEPTH is a power of two, so a full FIFO has only the top level bit set.
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && !empty_q && !flush_i;
  assign do_push = push_i && !flush_i && (!full_q || do_pop);

  // Occupancy is tracked by its own counter; pointers alone cannot
  // distinguish full from empty.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  // Storage needs no reset: entries are only visible through level/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/osp_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : osp_cmd_queue
// Purpose  : Buffers OSP commands written at bus rate and replays them to
//            osp_cmd_gen as mcu_cmd with a one-cycle mcu_cmd_write strobe,
//            spacing strobes by at least GAP cycles.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : wr_en/wr_data push commands; flush empties the queue;
//                  hold suspends new issues; ovf_clr clears sticky overflow;
//                  mcu_cmd/mcu_cmd_write issue; full/empty/level/overflow
// Build option : OSP_CMD_QUEUE_HOLD_EN - when defined, hold gates pops;
//                when undefined, hold is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module osp_cmd_queue
  import osp_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  osp_cmd_queue_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  issue_state_e  state_q;
  logic [GW-1:0] gap_q;
  osp_cmd_t      cmd_q;
  logic          write_q;
  logic          ovf_q;

  osp_cmd_t      head_w;
  logic [LW-1:0] level_w;
  logic          full_w;
  logic          empty_w;
  logic          hold_w;
  logic          pop_w;
  logic          drop_w;

`ifdef OSP_CMD_QUEUE_HOLD_EN
  assign hold_w = bus.hold;
`else
  logic unused_hold;
  assign unused_hold = bus.hold;
  assign hold_w      = 1'b0;
`endif

  // Issue whenever spacing has elapsed; the gap counter reaching zero in
  // WAIT allows a pop in that same cycle so strobes are exactly GAP apart.
  assign pop_w  = !empty_w && !hold_w && (gap_q == '0) && !bus.flush;
  assign drop_w = bus.wr_en && !bus.flush && full_w && !pop_w;

  osp_sync_fifo #(
    .WIDTH ($bits(osp_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.wr_en),
    .data_i  (bus.wr_data),
    .pop_i   (pop_w),
    .flush_i (bus.flush),
    .data_o  (head_w),
    .level_o (level_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      cmd_q   <= c_mcu_cmd_rst;
      write_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      write_q <= pop_w;
      if (pop_w) cmd_q <= head_w;

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_w) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end

      if (bus.flush) begin
        state_q <= ST_IDLE;
        gap_q   <= '0;
      end else if (pop_w) begin
        state_q <= ST_WAIT;
        gap_q   <= GAP_LOAD;
      end else if (state_q == ST_WAIT) begin
        if (gap_q == '0) begin
          state_q <= ST_IDLE;
        end else begin
          gap_q <= gap_q - GAP_ONE;
        end
      end
    end
  end

  assign bus.mcu_cmd       = cmd_q;
  assign bus.mcu_cmd_write = write_q;
  assign bus.level         = level_w;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.overflow      = ovf_q;

endmodule
`default_nettype wire

// File: doc/osp_cmd_queue.md
# osp_cmd_queue

Command buffer between the MCU bus-write decode and `osp_cmd_gen`. It accepts 16-bit OSP commands at bus rate and stores them in a small FIFO. It replays them to `osp_cmd_gen` as `mcu_cmd` with a single-cycle `mcu_cmd_write` strobe, enforcing a minimum spacing between strobes. An overflow flag, a flush input and a hold input are provided so firmware bursts and fault handling never produce lost or malformed strobes.

## Interface
- `DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `GAP`, 4: minimum clk cycles between consecutive `mcu_cmd_write` rising edges; at least 2.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `wr_en`  in  1  bus write strobe, one command per asserted cycle.
- `wr_data`  in  16  command word.
- `flush`  in  1  discard all queued commands.
- `hold`  in  1  suspend issuing; driven from `sys_hard_fault` at top level.
- `ovf_clr`  in  1  clear sticky overflow.
- `mcu_cmd`  out  16  last issued command.
- `mcu_cmd_write`  out  1  one-cycle issue strobe.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  entries queued.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- Reset values: `mcu_cmd` = 0, `mcu_cmd_write` = 0, `level` = 0, `empty` = 1, `full` = 0, `overflow` = 0, FSM in IDLE, gap counter = 0.
- Push: `wr_en` && !`flush` && (!`full` || pop this cycle) stores `wr_data` at the tail.
- Dropped write: `wr_en` && `full` && no pop. Set `overflow`; FIFO contents unchanged.
- Overflow clear: `ovf_clr` clears `overflow`. If `ovf_clr` and a dropped write occur in the same cycle, set wins.
- Issue FSM, IDLE state: pop when !`empty` && !`hold` && gap counter == 0. On pop, register the head into `mcu_cmd`, assert `mcu_cmd_write` next cycle, load the gap counter with GAP-1, go to WAIT.
- Issue FSM, WAIT state: decrement the counter. At 0, go to IDLE. A pop may happen in that same cycle, so back-to-back strobes are exactly GAP cycles apart.
- `hold`: blocks only new pops. An already registered strobe still completes, and the gap counter keeps counting.
- `flush`: next cycle `level` = 0 and the FSM is in IDLE with the gap counter cleared. `mcu_cmd` is unchanged; a strobe already registered still completes.
- `flush` with `wr_en` in the same cycle: the write is discarded, and `overflow` is not set.
- `flush` with a pop in the same cycle: no pop occurs.
- Pointers wrap modulo DEPTH. `level` is a separate counter updated by +1, -1 or 0 on push/pop, and is never derived from pointer subtraction alone.

## Timing
- Latency: `wr_en` sampled at edge N into an empty queue in IDLE gives `mcu_cmd_write` = 1 and `mcu_cmd` valid during cycle N+2.
- Queue drain rate: one command per GAP cycles.
- `mcu_cmd` changes only in the cycle `mcu_cmd_write` rises, then stays stable for at least GAP cycles.
- `level`, `full`, `empty` and `overflow` update one cycle after the causing edge. All outputs are registered.
- Reset mid-operation: all state returns to the reset values at the next edge. Queued commands are lost, and no strobe is emitted in the reset cycle.

## Configuration
- Macro: `OSP_CMD_QUEUE_HOLD_EN`.
- Defined: `hold` gates pops as described above.
- Undefined: the `hold` port is still present but ignored, and issuing depends only on FIFO state and the gap counter.

## Structure
- Package `osp_cmd_pkg` holds:
  - `osp_cmd_t`, a 16-bit command typedef;
  - the issue FSM enum (IDLE, WAIT);
  - the reset value constant for `mcu_cmd`.
- Sub-module `osp_sync_fifo`:
  - parameterized width/depth, with push, pop, flush, level, full and empty;
  - reusable by other OSP buffers.
- `osp_cmd_queue` contains `osp_sync_fifo`, the issue FSM, the gap counter and the overflow logic.

## Test plan
- Single write 0x1234 into an idle queue -> `mcu_cmd_write` high for exactly 1 cycle at N+2 with `mcu_cmd` = 0x1234; `level` returns to 0.
- Burst of 5 writes 0x0001–0x0005 with GAP = 4 -> five strobes with rising edges 4 cycles apart, in order; `mcu_cmd` holds 0x0005 afterwards.
- Writes 0x0101–0x010A into a DEPTH = 8 queue with `hold` = 1 -> `full` = 1 after 8 writes, `overflow` = 1, the 9th and 10th are dropped. After `hold` is released, exactly 8 strobes issue. Then `ovf_clr` -> `overflow` = 0.
- Write on the cycle a pop frees a full queue -> accepted, `overflow` stays 0, `level` stays 8.
- `flush` asserted during WAIT with 3 entries queued and `wr_en` = 1 in the same cycle -> `level` = 0 next cycle, no further strobes, `overflow` = 0, `mcu_cmd` unchanged.
- `reset_n` = 0 for one cycle mid-burst -> all outputs at reset values the next cycle; no strobe while `reset_n` = 0. Rebuild with `OSP_CMD_QUEUE_HOLD_EN` undefined -> `hold` = 1 has no effect on strobes.
